puf_key_sequencer: RTL and testbench

Sequences PUF enrollment reads to build the 128-bit ASCON key. For each of 8 key words it issues a challenge to the PUF and reads the PUF three times, then takes a bitwise majority vote of the three responses. The 8 voted words are packed into the key. The block sits between the ASCON core (key consumer) and the PUF macro (16-bit response source), and adds timeout and stability checks.

---
 rtl/puf_key_sequencer_if.sv | 23 ++
 rtl/puf_key_sequencer.sv | 157 +++++++++++++++
 tb/tb_puf_key_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_key_sequencer_if.sv
// rtl/puf_key_sequencer_if.sv - Key consumer and PUF macro signals for puf_key_sequencer
interface puf_key_sequencer_if;
  logic         key_req;
  logic         key_ack;
  logic         puf_start;
  logic [15:0]  challenge;
  logic         puf_valid;
  logic [15:0]  puf_response;
  logic [127:0] ascon_key;
  logic         key_valid;
  logic         key_error;
  logic         key_busy;

  modport master (
    input  key_req, key_ack, puf_valid, puf_response,
    output puf_start, challenge, ascon_key, key_valid, key_error, key_busy
  );

  modport slave (
    output key_req, key_ack, puf_valid, puf_response,
    input  puf_start, challenge, ascon_key, key_valid, key_error, key_busy
  );
endinterface

// File: rtl/puf_key_sequencer.sv
// rtl/puf_key_sequencer.sv - Builds a 128-bit key from 8 majority-voted PUF words
module puf_key_sequencer #(
  parameter logic [15:0] CHALLENGE_BASE = 16'h0001,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          UNSTABLE_MAX   = 4
) (
  input  logic                clk,
  input  logic                rst,
  puf_key_sequencer_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_VOTE, S_DONE, S_ERROR
  } state_t;

  state_t         state_q, state_n;
  logic [2:0]     word_idx_q, word_idx_n;
  logic [1:0]     rep_q, rep_n;
  logic [TW-1:0]  timer_q, timer_n;
  logic [15:0]    s0_q, s1_q, s2_q, s0_n, s1_n, s2_n;
  logic           puf_start_q, puf_start_n;
  logic [15:0]    challenge_q, challenge_n;
  logic [127:0]   key_q, key_n;
  logic           key_valid_q, key_valid_n;
  logic           key_error_q, key_error_n;
  logic           busy_q, busy_n;

  logic [15:0]    vote_word;
  logic [15:0]    diff;
  logic [4:0]     unstable;

  assign vote_word = (s0_q & s1_q) | (s1_q & s2_q) | (s0_q & s2_q);
  assign diff      = (s0_q ^ s1_q) | (s1_q ^ s2_q);

  always_comb begin
    unstable = '0;
    for (int i = 0; i < 16; i++) begin
      unstable = unstable + {4'd0, diff[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_idx_q  <= '0;
      rep_q       <= '0;
      timer_q     <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      puf_start_q <= 1'b0;
      challenge_q <= CHALLENGE_BASE;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      word_idx_q  <= word_idx_n;
      rep_q       <= rep_n;
      timer_q     <= timer_n;
      s0_q        <= s0_n;
      s1_q        <= s1_n;
      s2_q        <= s2_n;
      puf_start_q <= puf_start_n;
      challenge_q <= challenge_n;
      key_q       <= key_n;
      key_valid_q <= key_valid_n;
      key_error_q <= key_error_n;
      busy_q      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    word_idx_n  = word_idx_q;
    rep_n       = rep_q;
    timer_n     = timer_q;
    s0_n        = s0_q;
    s1_n        = s1_q;
    s2_n        = s2_q;
    key_n       = key_q;
    challenge_n = challenge_q;

    case (state_q)
      S_IDLE: begin
        if (bus.key_req) begin
          word_idx_n = '0;
          rep_n      = '0;
          key_n      = '0;
          state_n    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_n = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // A response landing on the last timeout cycle is still accepted
        if (bus.puf_valid) begin
          case (rep_q)
            2'd0:    s0_n = bus.puf_response;
            2'd1:    s1_n = bus.puf_response;
            default: s2_n = bus.puf_response;
          endcase
          if (rep_q < 2'd2) begin
            rep_n   = rep_q + 2'd1;
            state_n = S_ISSUE;
          end else begin
            rep_n   = '0;
            state_n = S_VOTE;
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = S_ERROR;
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end
      S_VOTE: begin
        if (unstable > 5'(UNSTABLE_MAX)) begin
          state_n = S_ERROR;
        end else begin
          key_n[{3'd7 - word_idx_q, 4'd0} +: 16] = vote_word;
          if (word_idx_q == 3'd7) begin
            state_n = S_DONE;
          end else begin
            word_idx_n = word_idx_q + 3'd1;
            state_n    = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (bus.key_ack) state_n = S_IDLE;
      end
      S_ERROR: begin
        if (bus.key_ack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are registered from the upcoming state so they align with it
    if (state_n == S_ISSUE) challenge_n = CHALLENGE_BASE + {13'd0, word_idx_n};
    if (state_n == S_ERROR) key_n = '0;
    puf_start_n = (state_n == S_ISSUE);
    key_valid_n = (state_n == S_DONE);
    key_error_n = (state_n == S_ERROR);
    busy_n      = (state_n != S_IDLE);
  end

  assign bus.puf_start = puf_start_q;
  assign bus.challenge = challenge_q;
  assign bus.ascon_key = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_error = key_error_q;
  assign bus.key_busy  = busy_q;
endmodule

// File: tb/tb_puf_key_sequencer.sv
// tb/tb_puf_key_sequencer.sv - Scoreboard bench for puf_key_sequencer
module tb_puf_key_sequencer;
  localparam logic [127:0] K_DEF = 128'hA5C2_A5C1_A5C0_A5C7_A5C6_A5C5_A5C4_A5CB;
  localparam logic [127:0] K_W5  = 128'hA5C2_A5C1_A5C0_A5C7_A5C6_1234_A5C4_A5CB;

  typedef struct packed {
    logic         err;
    logic [127:0] key;
  } exp_t;

  logic clk;
  logic rst;
  puf_key_sequencer_if bus();

  puf_key_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        exp_q[$];

  int          lat_s [24];
  logic [15:0] ovr [8][3];
  bit          ovr_en [8];
  bit          spurious = 1'b0;

  logic [15:0] chal_log[$];
  int          n_start = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit chal_ok(input int n);
    if (chal_log.size() != n) return 1'b0;
    for (int i = 0; i < n; i++) begin
      if (chal_log[i] !== 16'(16'h0001 + i / 3)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic cfg_default();
    for (int i = 0; i < 24; i++) lat_s[i] = 1;
    for (int i = 0; i < 8; i++) ovr_en[i] = 1'b0;
  endtask

  // PUF model: answers each puf_start after lat_s[n] WAIT cycles (0 = never)
  initial begin
    int          cnt;
    logic [15:0] cur_resp;
    bit          prev_busy;
    int          w;
    cnt = 0; cur_resp = '0; prev_busy = 1'b0;
    bus.puf_valid = 1'b0;
    bus.puf_response = '0;
    forever begin
      @(negedge clk);
      bus.puf_valid = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.puf_valid = 1'b1;
            bus.puf_response = cur_resp;
          end
        end
        if (spurious) begin
          bus.puf_valid = 1'b1;
          bus.puf_response = 16'($urandom);
        end
        if (bus.key_busy && !prev_busy) begin
          chal_log.delete();
          n_start = 0;
        end
        if (bus.puf_start && n_start < 24) begin
          chal_log.push_back(bus.challenge);
          w = n_start / 3;
          cur_resp = ovr_en[w] ? ovr[w][n_start % 3] : (16'hA5C3 ^ bus.challenge);
          cnt = lat_s[n_start];
          n_start++;
        end
      end
      prev_busy = bus.key_busy;
    end
  end

  // Scoreboard monitor: pops one expectation per key_valid/key_error rise
  initial begin
    bit   prev_v, prev_e;
    exp_t e;
    prev_v = 1'b0; prev_e = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus.key_valid && !prev_v) || (bus.key_error && !prev_e)) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_error_flag", bus.key_error, e.err);
          chk("sb_valid_flag", bus.key_valid, !e.err);
          chk("sb_key", bus.ascon_key, e.key);
        end
      end
      prev_v = bus.key_valid;
      prev_e = bus.key_error;
    end
  end

  task automatic req_pulse();
    @(negedge clk);
    bus.key_req = 1'b1;
    @(posedge clk);
    #1;
    bus.key_req = 1'b0;
  endtask

  task automatic wait_out(input int budget, output int edges, output bit busy_ok);
    edges = 0;
    busy_ok = 1'b1;
    while (!(bus.key_valid || bus.key_error) && edges < budget) begin
      if (!bus.key_busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
    if (!(bus.key_valid || bus.key_error)) chk("wait_budget_expired", 0, 1);
  endtask

  task automatic ack();
    @(negedge clk);
    bus.key_ack = 1'b1;
    @(negedge clk);
    bus.key_ack = 1'b0;
    chk("ack_valid_low", bus.key_valid, 0);
    chk("ack_error_low", bus.key_error, 0);
    chk("ack_idle", bus.key_busy, 0);
  endtask

  task automatic push_exp(input logic err, input logic [127:0] key);
    exp_t e;
    e.err = err;
    e.key = key;
    exp_q.push_back(e);
  endtask

  initial begin
    int edges;
    bit busy_ok;
    int k;
    bus.key_req = 1'b0;
    bus.key_ack = 1'b0;
    rst = 1'b1;
    cfg_default();
    for (int i = 0; i < 8; i++) for (int j = 0; j < 3; j++) ovr[i][j] = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_puf_start", bus.puf_start, 0);
    chk("rst_challenge", bus.challenge, 16'h0001);
    chk("rst_key", bus.ascon_key, 0);
    chk("rst_valid", bus.key_valid, 0);
    chk("rst_error", bus.key_error, 0);
    chk("rst_busy", bus.key_busy, 0);
    rst = 1'b0;

    // 1: nominal key, L=1
    push_exp(1'b0, K_DEF);
    req_pulse();
    wait_out(300, edges, busy_ok);
    chk("t1_latency", 128'(edges), 56);
    chk("t1_busy_throughout", busy_ok, 1);
    chk("t1_challenge_order", chal_ok(24), 1);
    ack();
    chk("t1_key_held_idle", bus.ascon_key, K_DEF);

    // 2: unstable word 2
    ovr_en[2] = 1'b1;
    ovr[2][0] = 16'h00FF; ovr[2][1] = 16'h00F0; ovr[2][2] = 16'h0F0F;
    push_exp(1'b1, 128'd0);
    req_pulse();
    wait_out(300, edges, busy_ok);
    chk("t2_error_edge", 128'(edges), 21);
    chk("t2_starts", 128'(n_start), 9);
    ack();

    // 3: one flaky bit on word 5 is tolerated
    cfg_default();
    ovr_en[5] = 1'b1;
    ovr[5][0] = 16'h1234; ovr[5][1] = 16'h1235; ovr[5][2] = 16'h1234;
    push_exp(1'b0, K_W5);
    req_pulse();
    wait_out(300, edges, busy_ok);
    chk("t3_latency", 128'(edges), 56);
    ack();

    // 4a: PUF silent on word 3
    cfg_default();
    lat_s[9] = 0;
    push_exp(1'b1, 128'd0);
    req_pulse();
    wait_out(3000, edges, busy_ok);
    chk("t4_timeout_edge", 128'(edges), 1046);
    chk("t4_timeout_starts", 128'(n_start), 10);
    ack();

    // 4b: response on the final timeout cycle wins
    cfg_default();
    lat_s[9] = 1024;
    push_exp(1'b0, K_DEF);
    req_pulse();
    wait_out(3000, edges, busy_ok);
    chk("t4_edge_accept_latency", 128'(edges), 1079);
    ack();

    // 5: async reset mid word 4
    cfg_default();
    lat_s[12] = 50;
    req_pulse();
    k = 0;
    while (n_start != 13 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("t5_reached_word4", 128'(n_start), 13);
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_rst_puf_start", bus.puf_start, 0);
    chk("t5_rst_challenge", bus.challenge, 16'h0001);
    chk("t5_rst_key", bus.ascon_key, 0);
    chk("t5_rst_valid", bus.key_valid, 0);
    chk("t5_rst_error", bus.key_error, 0);
    chk("t5_rst_busy", bus.key_busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cfg_default();
    push_exp(1'b0, K_DEF);
    req_pulse();
    wait_out(300, edges, busy_ok);
    chk("t5_latency", 128'(edges), 56);
    chk("t5_challenge_restart", chal_ok(24), 1);

    // 6: held key ignores req and puf_valid until acked
    spurious = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.key_req = ~bus.key_req;
    end
    @(negedge clk);
    spurious = 1'b0;
    bus.key_req = 1'b0;
    chk("t6_valid_held", bus.key_valid, 1);
    chk("t6_key_stable", bus.ascon_key, K_DEF);
    chk("t6_no_new_starts", 128'(n_start), 24);
    @(negedge clk);
    bus.key_ack = 1'b1;
    bus.key_req = 1'b1;
    @(negedge clk);
    bus.key_ack = 1'b0;
    bus.key_req = 1'b0;
    @(negedge clk);
    chk("t6_ack_req_idle", bus.key_busy, 0);
    chk("t6_ack_req_valid_low", bus.key_valid, 0);
    push_exp(1'b0, K_DEF);
    req_pulse();
    wait_out(300, edges, busy_ok);
    chk("t6_regen_latency", 128'(edges), 56);
    ack();

    repeat (3) @(negedge clk);
    chk("sb_queue_drained", 128'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
